exec_ctrl: RTL

EXEC_CTRL -- requirements
Module: exec_ctrl

---
 rtl/exec_ctrl.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/exec_ctrl.sv
// Accumulator execution controller: small ISA (ADD/SUB/LDI/NOP/MUL) driving a shared 8-bit ALU.
// MUL iterates ALU additions of imm into a product register, once per clock.
module alu8bit (
  input  logic [2:0] op,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] y,
  output logic       cout
);
  logic [8:0] s;

  // SUB computes b - a; cout = 1 means no borrow
  always_comb begin
    s = '0;
    case (op)
      3'b000:  s = {1'b0, b} + {1'b0, a};
      3'b001:  s = {1'b0, b} + {1'b0, ~a} + 9'd1;
      3'b010:  s = {1'b0, a};
      default: s = '0;
    endcase
    y    = s[7:0];
    cout = s[8];
  end
endmodule

module exec_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       instr_valid,
  input  logic [7:0] instr,
  output logic       instr_ready,
  output logic [7:0] acc,
  output logic       zflag,
  output logic       cflag,
  output logic       done,
  output logic       illegal,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, EXEC, MLOOP, DONE} state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_LDI = 3'b010;
  localparam logic [2:0] OP_NOP = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;

  state_t     state, state_nx;
  logic [2:0] opc;
  logic [4:0] imm;
  logic [7:0] product;
  logic [7:0] count;
  logic       carry_acc;

  logic [2:0] alu_op;
  logic [7:0] alu_a, alu_b, alu_y;
  logic       alu_c;
  logic       mul_trivial;

  assign mul_trivial = (acc == 8'h00) || (imm == 5'd0);

  alu8bit u_alu (
    .op   (alu_op),
    .a    (alu_a),
    .b    (alu_b),
    .y    (alu_y),
    .cout (alu_c)
  );

  always_comb begin
    state_nx    = state;
    alu_op      = 3'b000;
    alu_a       = 8'h00;
    alu_b       = acc;
    instr_ready = 1'b0;
    done        = 1'b0;
    illegal     = 1'b0;
    busy        = 1'b1;
    case (state)
      IDLE: begin
        instr_ready = 1'b1;
        busy        = 1'b0;
        if (instr_valid) state_nx = EXEC;
      end
      EXEC: begin
        alu_a = {3'b000, imm};
        case (opc)
          OP_SUB:  alu_op = 3'b001;
          OP_LDI:  alu_op = 3'b010;
          default: alu_op = 3'b000;
        endcase
        state_nx = (opc == OP_MUL && !mul_trivial) ? MLOOP : DONE;
      end
      MLOOP: begin
        alu_a = {3'b000, imm};
        alu_b = product;
        if (count == 8'd1) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        illegal  = (opc > OP_MUL);
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= 8'h00;
      zflag     <= 1'b1;
      cflag     <= 1'b0;
      opc       <= 3'b000;
      imm       <= 5'd0;
      product   <= 8'h00;
      count     <= 8'h00;
      carry_acc <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (instr_valid) begin
            opc <= instr[7:5];
            imm <= instr[4:0];
          end
        end
        EXEC: begin
          case (opc)
            OP_ADD, OP_SUB: begin
              acc   <= alu_y;
              cflag <= alu_c;
              zflag <= (alu_y == 8'h00);
            end
            OP_LDI: begin
              acc   <= alu_y;
              cflag <= 1'b0;
              zflag <= (imm == 5'd0);
            end
            OP_MUL: begin
              if (mul_trivial) begin
                acc   <= 8'h00;
                zflag <= 1'b1;
                cflag <= 1'b0;
              end else begin
                product   <= 8'h00;
                count     <= acc;
                carry_acc <= 1'b0;
              end
            end
            default: ;
          endcase
        end
        MLOOP: begin
          product   <= alu_y;
          carry_acc <= carry_acc | alu_c;
          count     <= count - 8'd1;
          // last iteration commits the product straight from the ALU
          if (count == 8'd1) begin
            acc   <= alu_y;
            cflag <= carry_acc | alu_c;
            zflag <= (alu_y == 8'h00);
          end
        end
        default: ;
      endcase
    end
  end
endmodule
